// File: rtl/uart_parity_gen_pkg.sv
// Shared UART parity definitions (package uart_pkg).
// Holds the parity type codes and calc_parity(), which both the TX-side
// parity generator and the RX deframer use, so the two sides cannot disagree.
package uart_pkg;

   localparam int PAR_EVEN      = 0;
   localparam int PAR_ODD       = 1;
   localparam int PAR_MARK      = 2;
   localparam int PAR_SPACE     = 3;

   // Widest legal character; narrower characters are zero-extended,
   // which does not change their XOR reduction.
   localparam int MAX_DATA_BITS = 9;

   function automatic logic calc_parity(
      input logic [MAX_DATA_BITS-1:0] data,
      input logic                     en,
      input int                       ptype
   );
      logic p;
      p = 1'b0;
      if (en) begin
         case (ptype)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_parity_gen_if.sv
// Character/parity handshake between a UART framer and the parity generator.
//   data_in, data_valid, rx_parity_bit : framer -> generator
//   parity_bit, parity_valid, parity_err : generator -> framer
// master = framer side, slave = parity generator.
interface uart_parity_gen_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_in;
   logic                 data_valid;
   logic                 rx_parity_bit;
   logic                 parity_bit;
   logic                 parity_valid;
   logic                 parity_err;

   modport master (
      output data_in, data_valid, rx_parity_bit,
      input  parity_bit, parity_valid, parity_err
   );

   modport slave (
      input  data_in, data_valid, rx_parity_bit,
      output parity_bit, parity_valid, parity_err
   );
endinterface

// File: rtl/uart_parity_gen_calc.sv
// uart_parity_calc: purely combinational parity of one character.
// Ports:
//   data_in  in  DATA_BITS  character
//   parity   out 1          parity bit for the configured type/enable
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 1,
   parameter int PARITY_TYPE = PAR_EVEN
) (
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 parity
);

   assign parity = calc_parity(MAX_DATA_BITS'(data_in), PARITY_EN != 0, PARITY_TYPE);

endmodule

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: registered parity generator/checker, 1-cycle latency.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active-high (dominates data_valid)
//   bus   slave side of uart_parity_gen_if
//         data_in/data_valid/rx_parity_bit in, parity_bit/parity_valid/parity_err out
// parity_bit/parity_err only load on an accepted character, so an idle or
// X-valued data_in never reaches the outputs.
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 1,
   parameter int PARITY_TYPE = PAR_EVEN
) (
   input logic               clk,
   input logic               rst,
   uart_parity_gen_if.slave  bus
);

   if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_width
      $error("uart_parity_gen: DATA_BITS=%0d outside 5..9", DATA_BITS);
   end
   if (PARITY_TYPE < PAR_EVEN || PARITY_TYPE > PAR_SPACE) begin : g_bad_type
      $error("uart_parity_gen: PARITY_TYPE=%0d outside 0..3", PARITY_TYPE);
   end

   logic p;
   logic parity_bit_q;
   logic parity_valid_q;
   logic parity_err_q;

   uart_parity_calc #(
      .DATA_BITS   (DATA_BITS),
      .PARITY_EN   (PARITY_EN),
      .PARITY_TYPE (PARITY_TYPE)
   ) u_calc (
      .data_in (bus.data_in),
      .parity  (p)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_bit_q   <= 1'b0;
         parity_valid_q <= 1'b0;
         parity_err_q   <= 1'b0;
      end else begin
         parity_valid_q <= bus.data_valid;
         if (bus.data_valid) begin
            parity_bit_q <= p;
            // With parity disabled there is nothing to check against.
            parity_err_q <= (PARITY_EN != 0) ? (bus.rx_parity_bit ^ p) : 1'b0;
         end
      end
   end

   assign bus.parity_bit   = parity_bit_q;
   assign bus.parity_valid = parity_valid_q;
   assign bus.parity_err   = parity_err_q;

endmodule

// File: tb/tb_uart_parity_gen.sv
module tb_uart_parity_gen;
   import uart_pkg::*;

   localparam int NI = 6;
   // Instances: even8, odd8, mark8, space8, disabled8, odd5
   localparam int PT [NI] = '{PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE, PAR_EVEN, PAR_ODD};
   localparam int EN [NI] = '{1, 1, 1, 1, 0, 1};
   localparam int W  [NI] = '{8, 8, 8, 8, 8, 5};

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       rx_parity_bit;

   logic obs_v [NI];
   logic obs_b [NI];
   logic obs_e [NI];

   logic exp_v;
   logic exp_b [NI];
   logic exp_e [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      uart_parity_gen_if #(.DATA_BITS(W[k])) bus ();
      assign bus.data_in       = data_in[W[k]-1:0];
      assign bus.data_valid    = data_valid;
      assign bus.rx_parity_bit = rx_parity_bit;
      assign obs_v[k] = bus.parity_valid;
      assign obs_b[k] = bus.parity_bit;
      assign obs_e[k] = bus.parity_err;

      uart_parity_gen #(
         .DATA_BITS   (W[k]),
         .PARITY_EN   (EN[k]),
         .PARITY_TYPE (PT[k])
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   // Reference: parity from the count of ones in the character.
   function automatic logic model_p(int k, logic [7:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < W[k]; i++) ones += int'(d[i]);
      if (EN[k] == 0) return 1'b0;
      case (PT[k])
         PAR_EVEN: return (ones % 2) == 1;
         PAR_ODD:  return (ones % 2) == 0;
         PAR_MARK: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   // Applies one cycle of stimulus, advances the reference, returns #1 after the edge.
   task automatic drive(input logic [7:0] d, input logic v, input logic rx, input logic r);
      data_in       = d;
      data_valid    = v;
      rx_parity_bit = rx;
      rst           = r;
      @(posedge clk);
      if (r) begin
         exp_v = 1'b0;
         for (int k = 0; k < NI; k++) begin exp_b[k] = 1'b0; exp_e[k] = 1'b0; end
      end else begin
         exp_v = v;
         if (v) for (int k = 0; k < NI; k++) begin
            exp_b[k] = model_p(k, d);
            exp_e[k] = (EN[k] != 0) ? (rx ^ exp_b[k]) : 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      drive(8'hFF, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if ({obs_v[k], obs_b[k], obs_e[k]} !== 3'b000) begin
            failures++;
            $display("FAIL reset inst%0d got v/b/e=%b%b%b want 000", k, obs_v[k], obs_b[k], obs_e[k]);
         end
      end
   endtask

   task automatic test_directed;
      drive(8'h17, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({obs_v[0], obs_b[0]} !== 2'b10) begin
         failures++; $display("FAIL even_17 got v/b=%b%b want 10", obs_v[0], obs_b[0]);
      end
      checks++;
      if ({obs_b[1], obs_e[1]} !== 2'b11) begin
         failures++; $display("FAIL odd_17_err got b/e=%b%b want 11", obs_b[1], obs_e[1]);
      end
      checks++;
      if (obs_b[5] !== 1'b1) begin
         failures++; $display("FAIL odd5_17 got %b want 1", obs_b[5]);
      end
      drive(8'h07, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({obs_b[0], obs_b[1]} !== 2'b10) begin
         failures++; $display("FAIL even_odd_07 got %b%b want 10", obs_b[0], obs_b[1]);
      end
      checks++;
      if ({obs_v[4], obs_b[4], obs_e[4]} !== 3'b100) begin
         failures++; $display("FAIL disabled_07 got v/b/e=%b%b%b want 100", obs_v[4], obs_b[4], obs_e[4]);
      end
      drive(8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({obs_b[2], obs_b[3]} !== 2'b10) begin
         failures++; $display("FAIL mark_space_00 got %b%b want 10", obs_b[2], obs_b[3]);
      end
      drive(8'hFF, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({obs_b[2], obs_b[3], obs_e[2], obs_e[3]} !== 4'b1001) begin
         failures++; $display("FAIL mark_space_ff got b/b/e/e=%b%b%b%b want 1001",
                              obs_b[2], obs_b[3], obs_e[2], obs_e[3]);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] stream [5] = '{8'h0F, 8'hAF, 8'hA9, 8'hBD, 8'h07};
      logic       want   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         drive(stream[i], 1'b1, 1'b0, 1'b0);
         checks++;
         if ({obs_v[0], obs_b[0]} !== {1'b1, want[i]}) begin
            failures++;
            $display("FAIL b2b_%0d got v/b=%b%b want 1%b", i, obs_v[0], obs_b[0], want[i]);
         end
      end
   endtask

   task automatic test_hold;
      drive(8'h01, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(8'($urandom), 1'b0, 1'($urandom), 1'b0);
         for (int k = 0; k < NI; k++) begin
            checks++;
            if ({obs_v[k], obs_b[k], obs_e[k]} !== {1'b0, exp_b[k], exp_e[k]}) begin
               failures++;
               $display("FAIL hold inst%0d got v/b/e=%b%b%b want 0%b%b",
                        k, obs_v[k], obs_b[k], obs_e[k], exp_b[k], exp_e[k]);
            end
         end
      end
   endtask

   task automatic test_reset_collision;
      drive(8'h07, 1'b1, 1'b0, 1'b0);
      drive(8'h07, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if ({obs_v[k], obs_b[k], obs_e[k]} !== 3'b000) begin
            failures++;
            $display("FAIL rst_vs_valid inst%0d got v/b/e=%b%b%b want 000", k, obs_v[k], obs_b[k], obs_e[k]);
         end
      end
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({obs_b[2], obs_v[2]} !== 2'b00) begin
         failures++; $display("FAIL rst_hold_mark got b/v=%b%b want 00", obs_b[2], obs_v[2]);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         drive(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 31) == 0));
         for (int k = 0; k < NI; k++) begin
            checks++;
            if ({obs_v[k], obs_b[k], obs_e[k]} !== {exp_v, exp_b[k], exp_e[k]}) begin
               failures++;
               $display("FAIL random_%0d inst%0d got v/b/e=%b%b%b want %b%b%b",
                        i, k, obs_v[k], obs_b[k], obs_e[k], exp_v, exp_b[k], exp_e[k]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; data_valid = 1'b0; data_in = 8'h00; rx_parity_bit = 1'b0;
      exp_v = 1'b0;
      for (int k = 0; k < NI; k++) begin exp_b[k] = 1'b0; exp_e[k] = 1'b0; end
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold();
      test_reset_collision();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
